// File: rtl/operand_fetch_stage.sv
// Operand fetch: resolves three operands from a 16-entry channel file or block registers,
// tracks in-flight channel writes with a scoreboard, and presents one registered output bundle.
module operand_fetch_stage #(
    parameter int data_width = 16,
    parameter int n_blocks   = 256,
    parameter int ctrl_width = 48,
    localparam int block_width = (n_blocks > 1) ? $clog2(n_blocks) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,

    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [block_width-1:0] block_in,
    input  logic [data_width-1:0]  register_0_in,
    input  logic [data_width-1:0]  register_1_in,
    input  logic [3:0]             src_a_in,
    input  logic [3:0]             src_b_in,
    input  logic [3:0]             src_c_in,
    input  logic                   src_a_reg_in,
    input  logic                   src_b_reg_in,
    input  logic                   src_c_reg_in,
    input  logic                   arg_a_needed_in,
    input  logic                   arg_b_needed_in,
    input  logic                   arg_c_needed_in,
    input  logic [3:0]             dest_in,
    input  logic                   writes_channel_in,
    input  logic [ctrl_width-1:0]  ctrl_in,

    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [block_width-1:0] block_out,
    output logic [3:0]             dest_out,
    output logic                   writes_channel_out,
    output logic [ctrl_width-1:0]  ctrl_out,
    output logic [data_width-1:0]  arg_a_out,
    output logic [data_width-1:0]  arg_b_out,
    output logic [data_width-1:0]  arg_c_out,

    input  logic                   wb_valid,
    input  logic [3:0]             wb_dest,
    input  logic [data_width-1:0]  wb_data
);

    localparam int n_chan = 16;
    localparam int n_ops  = 3;

    // Channel file and scoreboard
    logic [data_width-1:0] chan_reg [n_chan];
    logic [n_chan-1:0]     pend_reg;
    logic [n_chan-1:0]     pend_next;
    logic [n_chan-1:0]     wb_hit;

    // Output stage
    logic                   out_valid_reg;
    logic [block_width-1:0] block_reg;
    logic [3:0]             dest_reg;
    logic                   writes_channel_reg;
    logic [ctrl_width-1:0]  ctrl_reg;
    logic [data_width-1:0]  arg_a_reg;
    logic [data_width-1:0]  arg_b_reg;
    logic [data_width-1:0]  arg_c_reg;

    // Per-operand views so the three operand paths share one generate body
    logic [n_ops-1:0][3:0]            src;
    logic [n_ops-1:0]                 src_is_reg;
    logic [n_ops-1:0]                 needed;
    logic [n_ops-1:0]                 fwd_hit;
    logic [n_ops-1:0]                 hazard_src;
    logic [n_ops-1:0][data_width-1:0] operand_val;

    logic hazard_dest;
    logic take_in;
    logic take_out;

    assign src        = {src_c_in, src_b_in, src_a_in};
    assign src_is_reg = {src_c_reg_in, src_b_reg_in, src_a_reg_in};
    assign needed     = {arg_c_needed_in, arg_b_needed_in, arg_a_needed_in};

    genvar gi;
    generate
        for (gi = 0; gi < n_ops; gi++) begin : g_operand
            assign fwd_hit[gi] = wb_valid && (wb_dest == src[gi]);

            // Block registers take priority, then same-cycle writeback, then the file
            assign operand_val[gi] = src_is_reg[gi] ? (src[gi][0] ? register_1_in : register_0_in)
                                   : fwd_hit[gi]    ? wb_data
                                   :                  chan_reg[src[gi]];

            assign hazard_src[gi] = needed[gi] && !src_is_reg[gi]
                                 && pend_reg[src[gi]] && !fwd_hit[gi];
        end

        for (gi = 0; gi < n_chan; gi++) begin : g_chan
            assign wb_hit[gi] = wb_valid && (wb_dest == 4'(gi));

            // An issuing write claims the entry even if a writeback retires it this cycle
            assign pend_next[gi] = (take_in && writes_channel_in && (dest_in == 4'(gi))) ? 1'b1
                                 : wb_hit[gi] ? 1'b0
                                 : pend_reg[gi];
        end
    endgenerate

    assign hazard_dest = writes_channel_in && pend_reg[dest_in]
                      && !(wb_valid && (wb_dest == dest_in));

    assign in_ready = enable && (!out_valid_reg || out_ready)
                   && !(|hazard_src) && !hazard_dest;
    assign take_in  = in_valid && in_ready;
    assign take_out = enable && out_valid_reg && out_ready;

    // Writebacks and scoreboard clears proceed independently of enable
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_reg <= '0;
            for (int i = 0; i < n_chan; i++) begin
                chan_reg[i] <= '0;
            end
        end else begin
            pend_reg <= pend_next;
            for (int i = 0; i < n_chan; i++) begin
                if (wb_hit[i]) begin
                    chan_reg[i] <= wb_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg      <= 1'b0;
            block_reg          <= '0;
            dest_reg           <= '0;
            writes_channel_reg <= 1'b0;
            ctrl_reg           <= '0;
            arg_a_reg          <= '0;
            arg_b_reg          <= '0;
            arg_c_reg          <= '0;
        end else if (take_in) begin
            out_valid_reg      <= 1'b1;
            block_reg          <= block_in;
            dest_reg           <= dest_in;
            writes_channel_reg <= writes_channel_in;
            ctrl_reg           <= ctrl_in;
            arg_a_reg          <= operand_val[0];
            arg_b_reg          <= operand_val[1];
            arg_c_reg          <= operand_val[2];
        end else if (take_out) begin
            out_valid_reg      <= 1'b0;
        end
    end

    assign out_valid          = out_valid_reg;
    assign block_out          = block_reg;
    assign dest_out           = dest_reg;
    assign writes_channel_out = writes_channel_reg;
    assign ctrl_out           = ctrl_reg;
    assign arg_a_out          = arg_a_reg;
    assign arg_b_out          = arg_b_reg;
    assign arg_c_out          = arg_c_reg;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: directed scenarios followed by random traffic,
// checked against a rule-level model of the channel file and pending set.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  block_in;
    logic [15:0] register_0_in, register_1_in;
    logic [3:0]  src_a_in, src_b_in, src_c_in;
    logic        src_a_reg_in, src_b_reg_in, src_c_reg_in;
    logic        arg_a_needed_in, arg_b_needed_in, arg_c_needed_in;
    logic [3:0]  dest_in;
    logic        writes_channel_in;
    logic [47:0] ctrl_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  block_out;
    logic [3:0]  dest_out;
    logic        writes_channel_out;
    logic [47:0] ctrl_out;
    logic [15:0] arg_a_out, arg_b_out, arg_c_out;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic [15:0] wb_data;

    operand_fetch_stage dut (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .block_in(block_in),
        .register_0_in(register_0_in), .register_1_in(register_1_in),
        .src_a_in(src_a_in), .src_b_in(src_b_in), .src_c_in(src_c_in),
        .src_a_reg_in(src_a_reg_in), .src_b_reg_in(src_b_reg_in), .src_c_reg_in(src_c_reg_in),
        .arg_a_needed_in(arg_a_needed_in), .arg_b_needed_in(arg_b_needed_in),
        .arg_c_needed_in(arg_c_needed_in),
        .dest_in(dest_in), .writes_channel_in(writes_channel_in), .ctrl_in(ctrl_in),
        .out_valid(out_valid), .out_ready(out_ready), .block_out(block_out),
        .dest_out(dest_out), .writes_channel_out(writes_channel_out), .ctrl_out(ctrl_out),
        .arg_a_out(arg_a_out), .arg_b_out(arg_b_out), .arg_c_out(arg_c_out),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  blk;
        logic [3:0]  dest;
        logic        wr;
        logic [47:0] ctrl;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
    } bundle_t;

    bundle_t     exp_q[$];
    int          checks = 0;
    int          passes = 0;

    // Reference state: channel contents, set of channels with writes in flight, output occupancy
    logic [15:0] m_chan [16];
    bit          m_pend [16];
    bit          m_ov;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    endtask

    function automatic logic [15:0] m_operand(input logic [3:0] s, input logic is_reg);
        if (is_reg) return s[0] ? register_1_in : register_0_in;
        if (wb_valid && wb_dest == s) return wb_data;
        return m_chan[s];
    endfunction

    function automatic bit m_blocked(input logic [3:0] s, input logic is_reg, input logic need);
        return need && !is_reg && m_pend[s] && !(wb_valid && wb_dest == s);
    endfunction

    // Call right after a falling edge with inputs set; returns at the next falling edge.
    task automatic step();
        bundle_t e;
        bit      ready;
        bit      acc;
        acc = 1'b0;
        #1;
        if (!reset) begin
            ready = enable && (!m_ov || out_ready)
                 && !m_blocked(src_a_in, src_a_reg_in, arg_a_needed_in)
                 && !m_blocked(src_b_in, src_b_reg_in, arg_b_needed_in)
                 && !m_blocked(src_c_in, src_c_reg_in, arg_c_needed_in)
                 && !(writes_channel_in && m_pend[dest_in] && !(wb_valid && wb_dest == dest_in));
            check("in_ready", 128'(in_ready), 128'(ready));
            acc = in_valid && ready;
            if (acc) begin
                e.blk  = block_in;
                e.dest = dest_in;
                e.wr   = writes_channel_in;
                e.ctrl = ctrl_in;
                e.a    = m_operand(src_a_in, src_a_reg_in);
                e.b    = m_operand(src_b_in, src_b_reg_in);
                e.c    = m_operand(src_c_in, src_c_reg_in);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_chan[i] = '0;
                m_pend[i] = 1'b0;
            end
            m_ov = 1'b0;
            exp_q.delete();
        end else begin
            if (wb_valid) begin
                m_chan[wb_dest] = wb_data;
                m_pend[wb_dest] = 1'b0;
            end
            if (acc && writes_channel_in) m_pend[dest_in] = 1'b1;
            if (acc) m_ov = 1'b1;
            else if (enable && out_ready) m_ov = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        enable = 1'b1; in_valid = 1'b0; block_in = '0;
        register_0_in = '0; register_1_in = '0;
        src_a_in = '0; src_b_in = '0; src_c_in = '0;
        src_a_reg_in = 1'b0; src_b_reg_in = 1'b0; src_c_reg_in = 1'b0;
        arg_a_needed_in = 1'b0; arg_b_needed_in = 1'b0; arg_c_needed_in = 1'b0;
        dest_in = '0; writes_channel_in = 1'b0; ctrl_in = '0;
        out_ready = 1'b1; wb_valid = 1'b0; wb_dest = '0; wb_data = '0;
    endtask

    task automatic rand_inputs();
        enable            = ($urandom_range(0, 9) != 0);
        in_valid          = ($urandom_range(0, 9) < 7);
        block_in          = 8'($urandom());
        register_0_in     = 16'($urandom());
        register_1_in     = 16'($urandom());
        src_a_in          = 4'($urandom_range(0, 7));
        src_b_in          = 4'($urandom_range(0, 7));
        src_c_in          = 4'($urandom_range(0, 7));
        src_a_reg_in      = ($urandom_range(0, 4) == 0);
        src_b_reg_in      = ($urandom_range(0, 4) == 0);
        src_c_reg_in      = ($urandom_range(0, 4) == 0);
        arg_a_needed_in   = ($urandom_range(0, 9) < 7);
        arg_b_needed_in   = ($urandom_range(0, 9) < 7);
        arg_c_needed_in   = ($urandom_range(0, 9) < 7);
        dest_in           = 4'($urandom_range(0, 7));
        writes_channel_in = $urandom_range(0, 1) == 1;
        ctrl_in           = 48'({$urandom(), $urandom()});
        out_ready         = ($urandom_range(0, 3) != 0);
        wb_valid          = $urandom_range(0, 1) == 1;
        wb_dest           = 4'($urandom_range(0, 7));
        wb_data           = 16'($urandom());
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_arg_a", 128'(arg_a_out), 128'(0));
        check("rst_arg_b", 128'(arg_b_out), 128'(0));
        check("rst_arg_c", 128'(arg_c_out), 128'(0));
        check("rst_misc", 128'({block_out, dest_out, writes_channel_out, ctrl_out}), 128'(0));
    endtask

    // Monitor: checks occupancy every cycle and retires one expectation per output transfer
    always begin
        bundle_t got;
        bundle_t want;
        @(negedge clk);
        #2;
        if (!reset) begin
            check("out_valid", 128'(out_valid), 128'(m_ov));
            if (out_valid && out_ready && enable) begin
                got = {block_out, dest_out, writes_channel_out, ctrl_out,
                       arg_a_out, arg_b_out, arg_c_out};
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 128'(got), 128'(0));
                end else begin
                    want = exp_q.pop_front();
                    check("bundle", 128'(got), 128'(want));
                end
            end
        end
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        m_ov = 1'b0;
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        check_reset_outputs();

        // Read of a zeroed channel appears one cycle later
        in_valid = 1'b1; src_a_in = 4'd3; arg_a_needed_in = 1'b1;
        step();
        check("t1_arg_a", 128'(arg_a_out), 128'(0));

        // Read-after-write stall resolved by a forwarded writeback
        clear_inputs(); wb_valid = 1'b1; wb_dest = 4'd5; wb_data = 16'h1234;
        step();
        clear_inputs(); in_valid = 1'b1; writes_channel_in = 1'b1; dest_in = 4'd5;
        step();
        clear_inputs(); in_valid = 1'b1; src_a_in = 4'd5; arg_a_needed_in = 1'b1;
        repeat (3) step();
        wb_valid = 1'b1; wb_dest = 4'd5; wb_data = 16'h00AB;
        step();
        check("t2_arg_a", 128'(arg_a_out), 128'(16'h00AB));

        // Block register source ignores a pending channel of the same index
        clear_inputs(); in_valid = 1'b1; writes_channel_in = 1'b1; dest_in = 4'd1;
        step();
        clear_inputs(); in_valid = 1'b1; src_b_reg_in = 1'b1; src_b_in = 4'd1;
        arg_b_needed_in = 1'b1; register_1_in = 16'h7FFF;
        step();
        check("t3_arg_b", 128'(arg_b_out), 128'(16'h7FFF));
        clear_inputs(); wb_valid = 1'b1; wb_dest = 4'd1; wb_data = 16'h0001;
        step();

        // Backpressure holds the output bundle
        clear_inputs(); in_valid = 1'b1; src_a_reg_in = 1'b1; register_0_in = 16'h1111;
        step();
        register_0_in = 16'h2222; out_ready = 1'b0;
        repeat (3) begin
            step();
            check("t4_hold_a", 128'(arg_a_out), 128'(16'h1111));
        end
        out_ready = 1'b1;
        step();
        check("t4_next_a", 128'(arg_a_out), 128'(16'h2222));

        // Issue and writeback on the same channel in one cycle: pending wins, data lands
        clear_inputs(); in_valid = 1'b1; writes_channel_in = 1'b1; dest_in = 4'd2;
        wb_valid = 1'b1; wb_dest = 4'd2; wb_data = 16'h5A5A;
        step();
        clear_inputs(); in_valid = 1'b1; src_a_in = 4'd2; arg_a_needed_in = 1'b1;
        step();
        arg_a_needed_in = 1'b0;
        step();
        check("t5_chan2", 128'(arg_a_out), 128'(16'h5A5A));
        clear_inputs(); wb_valid = 1'b1; wb_dest = 4'd2; wb_data = 16'h0F0F;
        step();

        // Reset with a held bundle and a pending channel
        clear_inputs(); in_valid = 1'b1; writes_channel_in = 1'b1; dest_in = 4'd3;
        out_ready = 1'b0; src_a_reg_in = 1'b1; register_0_in = 16'hBEEF;
        step();
        clear_inputs(); reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_outputs();
        in_valid = 1'b1; src_a_in = 4'd3; arg_a_needed_in = 1'b1;
        src_b_in = 4'd2; arg_b_needed_in = 1'b1; writes_channel_in = 1'b1; dest_in = 4'd3;
        step();
        check("t6_arg_a", 128'(arg_a_out), 128'(0));
        check("t6_arg_b", 128'(arg_b_out), 128'(0));
        clear_inputs(); wb_valid = 1'b1; wb_dest = 4'd3; wb_data = 16'h0003;
        step();

        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            step();
        end

        clear_inputs();
        repeat (4) step();
        check("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
